// File: rtl/audio_pkg.sv
// Shared defaults for the audio PWM DAC slice.
package audio_pkg;
  localparam int unsigned DEF_WIDTH      = 10;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_UCNT_W     = 16;
  localparam int unsigned PERIOD_MAX     = 2**DEF_WIDTH - 1;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; level is kept separately so full and empty stay distinct.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_level == LVL_W'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/audio_pwm_dac.sv
// Sample-stream to fixed-period PWM converter; duty reloads only at period boundaries.
module audio_pwm_dac
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned UCNT_W     = DEF_UCNT_W,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              pwm_out,
  output logic              period_start,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_duty;
  logic [UCNT_W-1:0] r_ucnt;
  logic              r_pwm;
  logic              r_pstart;

  logic              w_load;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WIDTH-1:0]  w_head;

  assign w_load       = en && (r_cnt == CNT_MAX);
  assign w_pop        = w_load && !w_empty;
  assign w_push       = sample_valid && !w_full;
  assign sample_ready = !w_full;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (sample_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  // Counter, duty reload and starvation accounting; empty is pre-push so no bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_ucnt <= '0;
    end else begin
      r_cnt <= en ? r_cnt + WIDTH'(1) : '0;
      if (w_pop) begin
        r_duty <= w_head;
      end else if (w_load && (r_ucnt != UCNT_MAX)) begin
        r_ucnt <= r_ucnt + UCNT_W'(1);
      end
    end
  end

  // Output bits lag the counter by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm    <= 1'b0;
      r_pstart <= 1'b0;
    end else begin
      r_pwm    <= en && (r_cnt < r_duty);
      r_pstart <= en && (r_cnt == '0);
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_pstart;
  assign underrun_cnt = r_ucnt;

endmodule
